video_rd_scheduler: RTL and testbench
=====================================

Name: video_rd_scheduler

Overview:
- Schedules frame-buffer burst reads that keep the display FIFO ahead of the 1080p60 timing generator's pixel requests.
- On each frame-start pulse it:
  - waits for in-flight bursts to drain;
  - flushes the FIFO;
  - selects the display bank from the writer's last completed frame;
  - issues bursts at increasing addresses, throttled by FIFO space and an outstanding-burst limit, until one frame of words has been requested.
- Sits between the video timing driver and the DDR read port.

Parameters:
- ADDR_W, 28, memory word-address width.
- BANK0_BASE, 28'h0000000, word address of frame bank 0.
- BANK1_BASE, 28'h0200000, word address of frame bank 1.
- FRAME_WORDS, 259200, words per frame (1920x1080 px, 16-bit, 128-bit words).
- BURST_LEN, 64, maximum words per burst (1..255).
- FIFO_DEPTH, 1024, display FIFO capacity in words.
- LEVEL_W, 11, width of fifo_level.
- MAX_OUT, 4, maximum outstanding bursts (1..15).

Ports:
- pixel_clk  in  1  clock, all logic on its rising edge.
- sys_rst  in  1  reset, synchronous, active-high.
- frst_pos  in  1  one-cycle frame-start pulse from the timing generator.
- wr_bank_done  in  1  one-cycle pulse: the writer completed a frame.
- wr_bank  in  1  bank index of the completed frame, valid with wr_bank_done.
- fifo_level  in  LEVEL_W  current display FIFO fill, in words.
- fifo_clr  out  1  one-cycle FIFO flush pulse.
- rd_req  out  1  burst request.
- rd_addr  out  ADDR_W  burst start word address.
- rd_len  out  8  burst length in words.
- rd_ack  in  1  request accepted this cycle (rd_req & rd_ack).
- rd_done  in  1  final word of one burst written into the FIFO.
- rd_bank  out  1  bank currently displayed.
- frame_err  out  1  one-cycle pulse: frst_pos arrived before the frame completed.
- busy  out  1  high in every state except IDLE and DONE.

Behaviour:
- Reset values: state IDLE; all outputs 0; rd_addr=BANK0_BASE; outstanding=0; words_left=0; pend_valid=0; pend_frst=0.
- States:
  - IDLE
  - DRAIN
  - FLUSH
  - CHECK
  - REQ
  - DONE
- IDLE/DONE:
  - Leave only on frst_pos, going to DRAIN.
  - frame_err stays 0 in these states.
- DRAIN:
  - Stay while outstanding != 0.
  - Go to FLUSH the cycle after outstanding reaches 0.
- FLUSH (exactly one cycle):
  - fifo_clr=1.
  - If pend_valid: rd_bank<=pend_bank and pend_valid<=0.
  - rd_addr <= base of the new rd_bank.
  - words_left <= FRAME_WORDS.
  - pend_frst <= 0.
  - Next state CHECK.
- CHECK:
  - If pend_frst: go to DRAIN.
  - Else if words_left==0: go to DONE.
  - Else if outstanding<MAX_OUT and fifo_level + (outstanding+1)*BURST_LEN <= FIFO_DEPTH: load rd_len = min(BURST_LEN, words_left) and go to REQ.
  - Else stay in CHECK.
  - The space sum is computed at LEVEL_W+4 bits with no overflow.
- REQ:
  - rd_req=1; rd_addr and rd_len are held stable until rd_ack.
  - On rd_ack:
    - rd_req drops the next cycle;
    - rd_addr += rd_len (wraps at 2^ADDR_W);
    - words_left -= rd_len;
    - outstanding++;
    - next state CHECK.
  - A request is never withdrawn, even if frst_pos occurs during REQ.
- Outstanding counter:
  - +1 on rd_ack in REQ, -1 on rd_done; both in the same cycle leaves it unchanged.
  - rd_done while outstanding==0 is ignored; the counter saturates at 0.
- frst_pos in DRAIN, FLUSH, CHECK or REQ:
  - frame_err pulses for 1 cycle;
  - pend_frst is set;
  - the current frame is abandoned at the next CHECK (REQ completes its handshake first).
  - frst_pos in DRAIN leaves the state DRAIN.
- wr_bank_done:
  - Latches pend_bank<=wr_bank and sets pend_valid=1 in any state; the latest pulse wins.
  - A pulse in the FLUSH cycle itself is held for the next frame; the FLUSH cycle uses the value latched before it.
- Latency: frst_pos in IDLE with outstanding==0 gives fifo_clr 2 cycles later and the first rd_req 4 cycles later.
- sys_rst asserted mid-burst returns to reset values immediately, with no drain. The system resets the FIFO and memory port together with this block.

Decomposition:
- Package video_rd_pkg holds:
  - the state enum;
  - default frame constants (FRAME_WORDS, BURST_LEN, bank bases);
  - the words_left width localparam, clog2(FRAME_WORDS+1).
- One natural sub-module: rd_outstanding_cnt, a saturating up/down counter with inc, dec and a count output.

Test Plan:
- Reset, then 20 idle cycles with no frst_pos -> all outputs 0, no rd_req, busy=0.
- FRAME_WORDS=200, BURST_LEN=64, fifo_level=0, immediate ack, rd_done 3 cycles after each ack -> bursts issued in order:
  - (0,64)
  - (64,64)
  - (128,64)
  - (192,8)
  - then DONE, with busy=0 and no further rd_req.
- Back-pressure, DEPTH=1024, outstanding=0: fifo_level=961 -> no rd_req; fifo_level=960 -> rd_req within 2 cycles.
- rd_ack delayed 5 cycles -> rd_req, rd_addr and rd_len constant for 6 cycles; exactly one address increment.
- wr_bank_done with wr_bank=1 mid-frame -> rd_bank stays 0 and addresses stay in bank 0; after the next frst_pos, rd_bank=1 and the first rd_addr=28'h0200000.
- frst_pos mid-frame with 2 bursts outstanding -> frame_err pulses once; no fifo_clr until both rd_done pulses arrive; fifo_clr 1 cycle after the second rd_done (the DRAIN->FLUSH step); then a new frame from the bank base.

Source files
------------

// File: rtl/video_rd_pkg.sv
// Shared types and default frame geometry for the display read scheduler.
package video_rd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_FLUSH,
    S_CHECK,
    S_REQ,
    S_DONE
  } state_e;

  localparam int unsigned DEF_FRAME_WORDS = 259200;
  localparam int unsigned DEF_BURST_LEN   = 64;
  localparam logic [27:0] DEF_BANK0_BASE  = 28'h0000000;
  localparam logic [27:0] DEF_BANK1_BASE  = 28'h0200000;

  function automatic int unsigned wl_width(input int unsigned frame_words);
    return $clog2(frame_words + 1);
  endfunction

  localparam int unsigned WL_W = wl_width(DEF_FRAME_WORDS);

endpackage

// File: rtl/rd_outstanding_cnt.sv
// Saturating up/down count of bursts issued but not yet landed in the FIFO.
module rd_outstanding_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic [W-1:0] next_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // A stray dec at zero is dropped rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i)
      cnt_d = cnt_q + 1'b1;
    else if (dec_i && !inc_i && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;
  assign next_o  = cnt_d;

endmodule

// File: rtl/video_rd_scheduler.sv
// Frame-buffer burst read scheduler feeding the display FIFO ahead of the
// timing generator; restarts at the latest completed bank on each frame start.
module video_rd_scheduler
  import video_rd_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 28,
  parameter logic [ADDR_W-1:0] BANK0_BASE  = DEF_BANK0_BASE,
  parameter logic [ADDR_W-1:0] BANK1_BASE  = DEF_BANK1_BASE,
  parameter int unsigned       FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int unsigned       BURST_LEN   = DEF_BURST_LEN,
  parameter int unsigned       FIFO_DEPTH  = 1024,
  parameter int unsigned       LEVEL_W     = 11,
  parameter int unsigned       MAX_OUT     = 4
) (
  input  logic               pixel_clk,
  input  logic               sys_rst,
  input  logic               frst_pos,
  input  logic               wr_bank_done,
  input  logic               wr_bank,
  input  logic [LEVEL_W-1:0] fifo_level,
  output logic               fifo_clr,
  output logic               rd_req,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic [7:0]         rd_len,
  input  logic               rd_ack,
  input  logic               rd_done,
  output logic               rd_bank,
  output logic               frame_err,
  output logic               busy
);

  localparam int unsigned WLW = wl_width(FRAME_WORDS);
  localparam int unsigned OW  = 4;
  localparam int unsigned SW  = LEVEL_W + 4;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]        rd_len_q, rd_len_d;
  logic [WLW-1:0]    words_left_q, words_left_d;
  logic              rd_bank_q, rd_bank_d;
  logic              pend_bank_q, pend_bank_d;
  logic              pend_valid_q, pend_valid_d;
  logic              pend_frst_q, pend_frst_d;

  logic [OW-1:0]     out_cnt, out_nxt;
  logic              ack_fire;
  logic [SW-1:0]     need;
  logic              space_ok;
  logic [7:0]        len_min;
  logic              new_bank;

  assign ack_fire = (state_q == S_REQ) && rd_ack;

  rd_outstanding_cnt #(.W(OW)) u_out_cnt (
    .clk_i   (pixel_clk),
    .rst_i   (sys_rst),
    .inc_i   (ack_fire),
    .dec_i   (rd_done),
    .count_o (out_cnt),
    .next_o  (out_nxt)
  );

  // Reserve room for every in-flight burst plus the one about to be issued.
  always_comb begin
    need     = SW'(fifo_level) + (SW'(out_cnt) + SW'(1)) * SW'(BURST_LEN);
    space_ok = (need <= SW'(FIFO_DEPTH)) && (32'(out_cnt) < MAX_OUT);
    if (32'(words_left_q) < BURST_LEN) len_min = 8'(words_left_q);
    else                               len_min = 8'(BURST_LEN);
  end

  assign new_bank = pend_valid_q ? pend_bank_q : rd_bank_q;

  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    rd_len_d     = rd_len_q;
    words_left_d = words_left_q;
    rd_bank_d    = rd_bank_q;
    pend_bank_d  = pend_bank_q;
    pend_valid_d = pend_valid_q;
    pend_frst_d  = pend_frst_q;
    fifo_clr     = 1'b0;
    frame_err    = 1'b0;
    busy         = (state_q != S_IDLE) && (state_q != S_DONE);

    case (state_q)
      S_IDLE, S_DONE: if (frst_pos) state_d = S_DRAIN;
      S_DRAIN:        if (out_nxt == '0) state_d = S_FLUSH;
      S_FLUSH: begin
        fifo_clr     = 1'b1;
        rd_bank_d    = new_bank;
        pend_valid_d = 1'b0;
        rd_addr_d    = new_bank ? BANK1_BASE : BANK0_BASE;
        words_left_d = WLW'(FRAME_WORDS);
        pend_frst_d  = 1'b0;
        state_d      = S_CHECK;
      end
      S_CHECK: begin
        if (pend_frst_q)              state_d = S_DRAIN;
        else if (words_left_q == '0)  state_d = S_DONE;
        else if (space_ok) begin
          rd_len_d = len_min;
          state_d  = S_REQ;
        end
      end
      S_REQ: if (rd_ack) begin
        rd_addr_d    = rd_addr_q + ADDR_W'(rd_len_q);
        words_left_d = words_left_q - WLW'(rd_len_q);
        state_d      = S_CHECK;
      end
      default: state_d = S_IDLE;
    endcase

    // Late writer pulses and frame starts override the FLUSH-cycle clears.
    if (wr_bank_done) begin
      pend_bank_d  = wr_bank;
      pend_valid_d = 1'b1;
    end
    if (frst_pos && busy) begin
      frame_err   = 1'b1;
      pend_frst_d = 1'b1;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      state_q      <= S_IDLE;
      rd_addr_q    <= BANK0_BASE;
      rd_len_q     <= '0;
      words_left_q <= '0;
      rd_bank_q    <= 1'b0;
      pend_bank_q  <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_frst_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      rd_len_q     <= rd_len_d;
      words_left_q <= words_left_d;
      rd_bank_q    <= rd_bank_d;
      pend_bank_q  <= pend_bank_d;
      pend_valid_q <= pend_valid_d;
      pend_frst_q  <= pend_frst_d;
    end
  end

  assign rd_req  = (state_q == S_REQ);
  assign rd_addr = rd_addr_q;
  assign rd_len  = rd_len_q;
  assign rd_bank = rd_bank_q;

endmodule

// File: tb/tb_video_rd_scheduler.sv
// Scenario bench for video_rd_scheduler with a small memory-port responder.
module tb_video_rd_scheduler;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        frst_pos = 1'b0, wr_bank_done = 1'b0, wr_bank = 1'b0;
  logic [10:0] fifo_level = '0;
  logic        fifo_clr, rd_req, rd_ack = 1'b0, rd_done = 1'b0;
  logic [27:0] rd_addr;
  logic [7:0]  rd_len;
  logic        rd_bank, frame_err, busy;

  int n_checks = 0, n_pass = 0;
  int n_clr = 0, n_err = 0, n_req = 0;
  int ack_delay = 0, req_cnt = 0;
  bit done_en = 1'b1;
  int done_cd[$];
  logic [35:0] exp_q[$];
  string cur_test = "none";

  video_rd_scheduler #(.FRAME_WORDS(200)) dut (
    .pixel_clk(clk), .sys_rst(sys_rst), .frst_pos(frst_pos),
    .wr_bank_done(wr_bank_done), .wr_bank(wr_bank), .fifo_level(fifo_level),
    .fifo_clr(fifo_clr), .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_ack(rd_ack), .rd_done(rd_done), .rd_bank(rd_bank),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // One clock: drive at negedge, responder acks/completes, sample 1ns later.
  task automatic step(input bit f, input bit wd, input bit wb, input bit md);
    logic [35:0] e;
    @(negedge clk);
    frst_pos = f; wr_bank_done = wd; wr_bank = wb;
    rd_done = md;
    for (int i = done_cd.size() - 1; i >= 0; i--) begin
      done_cd[i] = done_cd[i] - 1;
      if (done_cd[i] == 0) begin
        rd_done = 1'b1;
        done_cd.delete(i);
      end
    end
    rd_ack = 1'b0;
    if (rd_req) begin
      if (req_cnt == ack_delay) begin rd_ack = 1'b1; req_cnt = 0; end
      else req_cnt++;
    end
    #1;
    n_clr += int'(fifo_clr);
    n_err += int'(frame_err);
    n_req += int'(rd_req);
    if (rd_req && rd_ack) begin
      if (done_en) done_cd.push_back(3);
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL %s burst: unexpected addr=%h len=%0d", cur_test, rd_addr, rd_len);
      end else begin
        e = exp_q.pop_front();
        if ({rd_addr, rd_len} !== e)
          $display("FAIL %s burst: got addr=%h len=%0d want addr=%h len=%0d",
                   cur_test, rd_addr, rd_len, e[35:8], e[7:0]);
        else n_pass++;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_frame(input logic [27:0] base);
    exp_q.push_back({base,          8'd64});
    exp_q.push_back({base + 28'd64,  8'd64});
    exp_q.push_back({base + 28'd128, 8'd64});
    exp_q.push_back({base + 28'd192, 8'd8});
  endtask

  task automatic run_frame(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      if (!busy && done_cd.size() == 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    cur_test = "reset";
    sys_rst = 1'b1;
    idle(3);
    sys_rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if ({rd_req, fifo_clr, busy, frame_err, rd_bank, rd_addr, rd_len} !== 41'd0)
        $display("FAIL reset outputs cycle %0d: req=%b clr=%b busy=%b err=%b bank=%b addr=%h len=%0d want all 0",
                 i, rd_req, fifo_clr, busy, frame_err, rd_bank, rd_addr, rd_len);
      else n_pass++;
    end
  endtask

  task automatic test_frame();
    bit ok;
    cur_test = "frame";
    n_clr = 0; n_err = 0;
    push_frame(28'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      if (k == 2) begin
        n_checks++;
        if (fifo_clr !== 1'b1) $display("FAIL frame fifo_clr latency: got %b want 1", fifo_clr);
        else n_pass++;
      end
      if (k == 3 || k == 4) begin
        n_checks++;
        if (rd_req !== (k == 4)) $display("FAIL frame rd_req latency k=%0d: got %b want %b", k, rd_req, k == 4);
        else n_pass++;
      end
    end
    run_frame(200, ok);
    n_checks++;
    if (!ok) $display("FAIL frame timeout: got busy=%b want 0", busy); else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL frame missing bursts: got %0d left want 0", exp_q.size()); else n_pass++;
    n_req = 0;
    idle(20);
    n_checks++;
    if (n_req != 0 || busy !== 1'b0 || n_clr != 1 || n_err != 0)
      $display("FAIL frame after DONE: req=%0d busy=%b clr=%0d err=%0d want 0 0 1 0", n_req, busy, n_clr, n_err);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    bit ok, seen;
    cur_test = "backpressure";
    fifo_level = 11'd961;
    push_frame(28'h0);
    n_req = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(30);
    n_checks++;
    if (n_req != 0 || busy !== 1'b1) $display("FAIL backpressure level 961: req=%0d busy=%b want 0 1", n_req, busy);
    else n_pass++;
    fifo_level = 11'd960;
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      if (rd_req) seen = 1'b1;
    end
    n_checks++;
    if (!seen) $display("FAIL backpressure level 960: got no rd_req want rd_req within 2 cycles"); else n_pass++;
    run_frame(300, ok);
    n_checks++;
    if (!ok || exp_q.size() != 0) $display("FAIL backpressure frame: done=%b left=%0d want 1 0", ok, exp_q.size());
    else n_pass++;
    fifo_level = '0;
  endtask

  task automatic test_ack_delay();
    bit ok, seen;
    cur_test = "ack_delay";
    ack_delay = 5; req_cnt = 0;
    push_frame(28'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      seen = rd_req;
    end
    for (int i = 0; i < 6; i++) begin
      if (i != 0) step(1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if ({rd_req, rd_addr, rd_len} !== {1'b1, 28'h0, 8'd64})
        $display("FAIL ack_delay hold cycle %0d: req=%b addr=%h len=%0d want 1 0000000 64", i, rd_req, rd_addr, rd_len);
      else n_pass++;
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({rd_req, rd_addr} !== {1'b0, 28'd64})
      $display("FAIL ack_delay increment: req=%b addr=%h want 0 0000040", rd_req, rd_addr);
    else n_pass++;
    run_frame(400, ok);
    n_checks++;
    if (!ok || exp_q.size() != 0) $display("FAIL ack_delay frame: done=%b left=%0d want 1 0", ok, exp_q.size());
    else n_pass++;
    ack_delay = 0; req_cnt = 0;
  endtask

  task automatic test_bank_switch();
    bit ok;
    cur_test = "bank_switch";
    push_frame(28'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20 && exp_q.size() > 3; i++) idle(1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    run_frame(200, ok);
    n_checks++;
    if (!ok || rd_bank !== 1'b0 || exp_q.size() != 0)
      $display("FAIL bank_switch old frame: done=%b bank=%b left=%0d want 1 0 0", ok, rd_bank, exp_q.size());
    else n_pass++;
    push_frame(28'h0200000);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run_frame(200, ok);
    n_checks++;
    if (!ok || rd_bank !== 1'b1 || exp_q.size() != 0)
      $display("FAIL bank_switch new frame: done=%b bank=%b left=%0d want 1 1 0", ok, rd_bank, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_abort();
    bit ok;
    cur_test = "abort";
    fifo_level = 11'd896;
    done_en = 1'b0;
    exp_q.push_back({28'h0200000, 8'd64});
    exp_q.push_back({28'h0200040, 8'd64});
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) idle(1);
    idle(5);
    n_checks++;
    if (exp_q.size() != 0 || busy !== 1'b1 || rd_req !== 1'b0)
      $display("FAIL abort stall: left=%0d busy=%b req=%b want 0 1 0", exp_q.size(), busy, rd_req);
    else n_pass++;
    n_err = 0; n_clr = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (frame_err !== 1'b1) $display("FAIL abort frame_err: got %b want 1", frame_err); else n_pass++;
    idle(10);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);
    n_checks++;
    if (n_clr != 0 || n_err != 1) $display("FAIL abort drain: clr=%0d err=%0d want 0 1", n_clr, n_err);
    else n_pass++;
    fifo_level = '0;
    done_en = 1'b1;
    push_frame(28'h0200000);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (fifo_clr !== 1'b1) $display("FAIL abort fifo_clr after last done: got %b want 1", fifo_clr); else n_pass++;
    run_frame(200, ok);
    n_checks++;
    if (!ok || exp_q.size() != 0 || n_err != 1 || n_clr != 1)
      $display("FAIL abort restart: done=%b left=%0d err=%0d clr=%0d want 1 0 1 1", ok, exp_q.size(), n_err, n_clr);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_ack_delay();
    test_bank_switch();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
